// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_responder
//  Description : Memory responder between a datapath controller and an
//                asynchronous 16-bit SRAM. It also decodes one address as
//                memory-mapped I/O: reads there return the board switches,
//                and writes there load the hex display register.
//                Each request completes with exactly one R pulse. The
//                controller must drop its request before the next one is
//                accepted.
//  Ports       : clk, reset_n (async, active-low)
//                mem_read/mem_write/MAR/MDR  - request from control
//                MDR_In/R                    - read data and ready pulse
//                switches/hex_out            - MMIO input and display register
//                sram_*                      - SRAM address, data, tristate
//                                              enable and active-low strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_responder #(
    parameter int          WAIT_CYCLES = 2,        // 1..15 strobe-active cycles
    parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MDR_In,
    output logic        R,
    input  logic [15:0] switches,
    output logic [15:0] hex_out,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    // The counter is loaded on entry to ACCESS and reaches zero in the
    // last ACCESS cycle, so ACCESS lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_is_write;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [15:0] r_mdr_in;
    logic [15:0] r_hex;

    logic        w_req;
    logic        w_mmio;
    logic        w_last;

    assign w_req  = mem_read | mem_write;
    assign w_mmio = (MAR == MMIO_ADDR);
    assign w_last = (r_cnt == 4'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. Strobes decode from registered state, so an
    // asynchronous reset releases them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        R          = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = w_mmio ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_dq_oe = r_is_write;
                w_next     = S_ACCESS;
            end
            S_ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_oe_n  = r_is_write;
                sram_we_n  = ~r_is_write;
                sram_dq_oe = r_is_write;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                R      = 1'b1;
                w_next = S_RELEASE;
            end
            S_RELEASE: begin
                // Wait for the controller to drop the request so that a
                // held request is served only once.
                if (!w_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter, read data and display register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_write <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_cnt      <= 4'd0;
            r_mdr_in   <= 16'h0000;
            r_hex      <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Write wins when both requests are high.
                        r_is_write <= mem_write;
                        r_addr     <= MAR;
                        r_wdata    <= MDR;
                        if (w_mmio) begin
                            if (mem_write) begin
                                r_hex <= MDR;
                            end else begin
                                r_mdr_in <= switches;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    r_cnt <= c_CNT_INIT;
                end
                S_ACCESS: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_is_write) begin
                        r_mdr_in <= sram_dq_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MDR_In      = r_mdr_in;
    assign hex_out     = r_hex;
    assign sram_addr   = {4'b0000, r_addr};
    assign sram_dq_out = r_wdata;

endmodule
`default_nettype wire
